// File: rtl/dvp_capture.sv
`default_nettype none
// ============================================================================
// Module   : dvp_capture
// Brief    : DVP camera front end. Frame-aligned capture, RGB565 byte pairing,
//            geometry enforcement, sticky line/frame length errors.
//            Optional macro DVP_CAPTURE_TESTPAT_EN replaces pixels with a
//            coordinate pattern {x[8:4], y[8:3], x[8:4]}.
// Revision : 1.0 - initial release
// ============================================================================
module dvp_capture #(
    parameter int IMG_WIDTH         = 640,
    parameter int IMG_HEIGHT        = 480,
    parameter int HI_BYTE_FIRST     = 1,
    parameter int VSYNC_ACTIVE_HIGH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_enable,
    input  logic        err_clear,
    output logic        pixel_valid,
    output logic [15:0] pixel_out,
    output logic        vsync_out,
    output logic        frame_start,
    output logic        frame_done,
    output logic [9:0]  x_count,
    output logic [8:0]  y_count,
    output logic        line_len_err,
    output logic        frame_len_err
);

    localparam logic [1:0]  c_S_IDLE        = 2'd0;
    localparam logic [1:0]  c_S_WAIT_VS     = 2'd1;
    localparam logic [1:0]  c_S_WAIT_END_VS = 2'd2;
    localparam logic [1:0]  c_S_ACTIVE      = 2'd3;

    localparam logic [9:0]  c_WIDTH    = 10'(IMG_WIDTH);
    localparam logic [8:0]  c_HEIGHT   = 9'(IMG_HEIGHT);
    localparam logic [10:0] c_WIDTH_P1 = 11'(IMG_WIDTH + 1);

    logic [1:0]  r_state;
    logic        r_phase;
    logic        r_href_d;
    logic [7:0]  r_byte;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [10:0] r_line_pix;
    logic        r_pv;
    logic [15:0] r_pix;
    logic        r_vsync_out;
    logic        r_fs;
    logic        r_fd;
    logic        r_line_err;
    logic        r_frame_err;

    logic        w_vs;
    logic        w_line_end;
    logic        w_in_bounds;
    logic [8:0]  w_y_next;
    logic [15:0] w_pix;

    assign w_vs        = (VSYNC_ACTIVE_HIGH != 0) ? cam_vsync : ~cam_vsync;
    assign w_line_end  = ~cam_href & r_href_d;
    assign w_in_bounds = (r_x < c_WIDTH) && (r_y < c_HEIGHT);
    // y_count after this cycle's line end, so the frame check sees it too
    assign w_y_next    = (w_line_end && (r_y != c_HEIGHT)) ? r_y + 9'd1 : r_y;

`ifdef DVP_CAPTURE_TESTPAT_EN
    assign w_pix = {r_x[8:4], r_y[8:3], r_x[8:4]};
`else
    assign w_pix = (HI_BYTE_FIRST != 0) ? {r_byte, cam_data} : {cam_data, r_byte};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_phase     <= 1'b0;
            r_href_d    <= 1'b0;
            r_byte      <= 8'd0;
            r_x         <= 10'd0;
            r_y         <= 9'd0;
            r_line_pix  <= 11'd0;
            r_pv        <= 1'b0;
            r_pix       <= 16'd0;
            r_vsync_out <= 1'b0;
            r_fs        <= 1'b0;
            r_fd        <= 1'b0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_vsync_out <= w_vs;
            r_href_d    <= cam_href;
            r_pv        <= 1'b0;
            r_fs        <= 1'b0;
            r_fd        <= 1'b0;

            // Clear first so that any set below in the same cycle wins
            if (err_clear) begin
                r_line_err  <= 1'b0;
                r_frame_err <= 1'b0;
            end

            if (!capture_enable) begin
                r_state    <= c_S_IDLE;
                r_phase    <= 1'b0;
                r_x        <= 10'd0;
                r_y        <= 9'd0;
                r_line_pix <= 11'd0;
            end else begin
                case (r_state)
                    c_S_IDLE: r_state <= c_S_WAIT_VS;
                    c_S_WAIT_VS: begin
                        if (w_vs) r_state <= c_S_WAIT_END_VS;
                    end
                    c_S_WAIT_END_VS: begin
                        if (!w_vs) begin
                            r_state <= c_S_ACTIVE;
                            r_fs    <= 1'b1;
                        end
                    end
                    c_S_ACTIVE: begin
                        if (cam_href) begin
                            if (!r_href_d || !r_phase) begin
                                r_byte  <= cam_data;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if (r_line_pix != c_WIDTH_P1) r_line_pix <= r_line_pix + 11'd1;
                                if (w_in_bounds) begin
                                    r_pv  <= 1'b1;
                                    r_pix <= w_pix;
                                    r_x   <= r_x + 10'd1;
                                end
                            end
                        end else if (r_href_d) begin
                            if ((r_line_pix != {1'b0, c_WIDTH}) || r_phase) r_line_err <= 1'b1;
                            r_phase    <= 1'b0;
                            r_x        <= 10'd0;
                            r_line_pix <= 11'd0;
                            r_y        <= w_y_next;
                        end
                        if (w_vs) begin
                            if (w_y_next != c_HEIGHT) r_frame_err <= 1'b1;
                            r_state    <= c_S_WAIT_END_VS;
                            r_fd       <= 1'b1;
                            r_phase    <= 1'b0;
                            r_x        <= 10'd0;
                            r_y        <= 9'd0;
                            r_line_pix <= 11'd0;
                        end
                    end
                    default: r_state <= c_S_IDLE;
                endcase
            end
        end
    end

    assign pixel_valid   = r_pv;
    assign pixel_out     = r_pix;
    assign vsync_out     = r_vsync_out;
    assign frame_start   = r_fs;
    assign frame_done    = r_fd;
    assign x_count       = r_x;
    assign y_count       = r_y;
    assign line_len_err  = r_line_err;
    assign frame_len_err = r_frame_err;

endmodule
`default_nettype wire
